// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
//
// Turns a single-cycle exception (or MRET) seen in EX into an ordered
// trap-entry / trap-return sequence: stall, flush younger instructions,
// write the trap CSRs one at a time over a valid/ready port, then redirect
// fetch to the handler (mtvec) or the return address (mepc).
//
// Optional build macro:
//   TRAP_SEQ_VECTORED_EN - vectored interrupt dispatch when mtvec.MODE==1
//                          and the captured cause is an interrupt.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_exception_valid       exception present in EX this cycle
//   i_exception_cause/tval/pc  trap information to capture
//   i_mret                  MRET present in EX this cycle
//   i_mtvec, i_mepc         current CSR values (used for the redirect target)
//   i_mstatus               current mstatus (captured at trap/return start)
//   o_busy                  sequence in progress, stalls the pipeline
//   o_flush                 one-cycle flush of IF/ID/EX
//   o_csr_valid/addr/wdata  CSR write request, i_csr_ready accepts it
//   o_redirect_valid/pc     one-cycle fetch redirect
// ----------------------------------------------------------------------------
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_exception_valid,
  input  logic [XLEN-1:0] i_exception_cause,
  input  logic [XLEN-1:0] i_exception_tval,
  input  logic [XLEN-1:0] i_exception_pc,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mstatus,
  output logic            o_busy,
  output logic            o_flush,
  output logic            o_csr_valid,
  input  logic            i_csr_ready,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FLUSH      = 3'd1,
    S_WR_MEPC    = 3'd2,
    S_WR_MCAUSE  = 3'd3,
    S_WR_MTVAL   = 3'd4,
    S_WR_MSTATUS = 3'd5,
    S_REDIRECT   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_is_return;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_mstatus;

  logic            w_csr_fire;
  logic [XLEN-1:0] w_direct_base;
  logic [XLEN-1:0] w_return_pc;
  logic [XLEN-1:0] w_entry_target;
  logic            w_unused;

  // Trap entry: stash MIE into MPIE, disable interrupts, MPP = M-mode.
  function automatic logic [XLEN-1:0] mstatus_entry(input logic [XLEN-1:0] old);
    logic [XLEN-1:0] v;
    v        = old;
    v[7]     = old[3];
    v[3]     = 1'b0;
    v[12:11] = 2'b11;
    return v;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, MPP stays M-mode.
  function automatic logic [XLEN-1:0] mstatus_return(input logic [XLEN-1:0] old);
    logic [XLEN-1:0] v;
    v        = old;
    v[3]     = old[7];
    v[7]     = 1'b1;
    v[12:11] = 2'b11;
    return v;
  endfunction

  // A write is consumed only when the request is presented and accepted.
  assign w_csr_fire = o_csr_valid && i_csr_ready;

  // State register and capture registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_is_return <= 1'b0;
      r_cause     <= '0;
      r_tval      <= '0;
      r_pc        <= '0;
      r_mstatus   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE) begin
        if (i_exception_valid) begin
          r_cause     <= i_exception_cause;
          r_tval      <= i_exception_tval;
          r_pc        <= i_exception_pc;
          r_mstatus   <= i_mstatus;
          r_is_return <= 1'b0;
        end else if (i_mret) begin
          r_mstatus   <= i_mstatus;
          r_is_return <= 1'b1;
        end
      end
    end
  end

  // Next-state logic; requests are only honoured in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_exception_valid || i_mret) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH:      w_next_state = r_is_return ? S_WR_MSTATUS : S_WR_MEPC;
      S_WR_MEPC:    if (w_csr_fire) w_next_state = S_WR_MCAUSE;
      S_WR_MCAUSE:  if (w_csr_fire) w_next_state = S_WR_MTVAL;
      S_WR_MTVAL:   if (w_csr_fire) w_next_state = S_WR_MSTATUS;
      S_WR_MSTATUS: if (w_csr_fire) w_next_state = S_REDIRECT;
      S_REDIRECT:   w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // Redirect targets; mtvec/mepc are read live so the final CSR values apply.
  assign w_direct_base = {i_mtvec[XLEN-1:2], 2'b00};
  assign w_return_pc   = {i_mepc[XLEN-1:2], 2'b00};

`ifdef TRAP_SEQ_VECTORED_EN
  // Vectored mode: interrupts jump to base + 4*cause (cause MSB dropped).
  always_comb begin
    w_entry_target = w_direct_base;
    if ((i_mtvec[1:0] == 2'b01) && r_cause[XLEN-1]) begin
      w_entry_target = w_direct_base + {r_cause[XLEN-3:0], 2'b00};
    end
  end
`else
  assign w_entry_target = w_direct_base;
`endif

  // Bits intentionally not used by every build flavour.
  assign w_unused = ^{i_mtvec[1:0], i_mepc[1:0], r_cause[XLEN-1:XLEN-2]};

  // Output decode from registered state and captured values only.
  always_comb begin
    o_busy           = 1'b0;
    o_flush          = 1'b0;
    o_csr_valid      = 1'b0;
    o_csr_addr       = 12'h000;
    o_csr_wdata      = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    case (r_state)
      S_IDLE: ;
      S_FLUSH: begin
        o_busy  = 1'b1;
        o_flush = 1'b1;
      end
      S_WR_MEPC: begin
        o_busy      = 1'b1;
        o_csr_valid = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_wdata = r_pc;
      end
      S_WR_MCAUSE: begin
        o_busy      = 1'b1;
        o_csr_valid = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_wdata = r_cause;
      end
      S_WR_MTVAL: begin
        o_busy      = 1'b1;
        o_csr_valid = 1'b1;
        o_csr_addr  = CSR_MTVAL;
        o_csr_wdata = r_tval;
      end
      S_WR_MSTATUS: begin
        o_busy      = 1'b1;
        o_csr_valid = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_wdata = r_is_return ? mstatus_return(r_mstatus)
                                  : mstatus_entry(r_mstatus);
      end
      S_REDIRECT: begin
        o_busy           = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_is_return ? w_return_pc : w_entry_target;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that turns a single-cycle exception indication from the Execute stage (or an MRET) into an ordered trap-entry or trap-return sequence. It stalls the pipeline, flushes younger instructions, then writes mepc/mcause/mtval/mstatus one at a time over a valid/ready CSR write port. Finally it redirects fetch to the handler (mtvec) or the return address (mepc). It sits between the EX-stage exception logic and the CSR file / fetch redirect mux.

## Interface
- XLEN, 32, data/address width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_exception_valid  in  1  synchronous exception present in EX this cycle
- i_exception_cause  in  XLEN  mcause value (bit XLEN-1 = interrupt flag)
- i_exception_tval  in  XLEN  mtval value
- i_exception_pc  in  XLEN  PC of faulting instruction
- i_mret  in  1  MRET present in EX this cycle
- i_mtvec  in  XLEN  current mtvec CSR
- i_mepc  in  XLEN  current mepc CSR
- i_mstatus  in  XLEN  current mstatus CSR
- o_busy  out  1  sequence in progress (pipeline stall)
- o_flush  out  1  one-cycle flush of IF/ID/EX
- o_csr_valid  out  1  CSR write request
- i_csr_ready  in  1  CSR file accepts write this cycle
- o_csr_addr  out  12  CSR address
- o_csr_wdata  out  XLEN  CSR write data
- o_redirect_valid  out  1  one-cycle fetch redirect
- o_redirect_pc  out  XLEN  redirect target

## Operation
- States: IDLE, FLUSH, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, REDIRECT; one flag register `is_return` selects the entry or return flavour.
- IDLE with i_exception_valid:
  - capture cause, tval, pc and mstatus;
  - is_return=0;
  - go to FLUSH.
- IDLE with i_mret and no exception:
  - capture mstatus, is_return=1;
  - go to FLUSH.
- If both arrive in the same cycle, the exception wins.
- FLUSH: o_flush=1 for exactly one cycle.
  - Entry: go to WR_MEPC.
  - Return: go to WR_MSTATUS.
- WR_MEPC: addr 0x341, data = captured pc.
- WR_MCAUSE: addr 0x342, data = captured cause.
- WR_MTVAL: addr 0x343, data = captured tval.
- WR_MSTATUS, addr 0x300:
  - Entry data: MPIE(bit7) = old MIE(bit3), MIE=0, MPP[12:11]=2'b11, all other bits unchanged.
  - Return data: MIE = old MPIE, MPIE=1, MPP=2'b11, others unchanged.
- CSR handshake rules:
  - In every WR_* state o_csr_valid=1.
  - The state advances only on the cycle where o_csr_valid && i_csr_ready.
  - addr/data are held stable while waiting.
  - Write order for entry: mepc → mcause → mtval → mstatus. For return: mstatus only.
- REDIRECT: o_redirect_valid=1 for one cycle, then IDLE.
  - Entry target: {i_mtvec[XLEN-1:2],2'b00}.
  - Return target: {i_mepc[XLEN-1:2],2'b00}.
  - mtvec/mepc are sampled combinationally in REDIRECT, after all CSR writes have completed.
- o_busy=1 in every state except IDLE.
- i_exception_valid and i_mret are ignored while busy; the pipeline is stalled and the EX contents get flushed.

## Timing
- Reset values:
  - state=IDLE;
  - o_busy, o_flush, o_csr_valid, o_redirect_valid = 0;
  - o_csr_addr=0, o_csr_wdata=0, o_redirect_pc=0;
  - captured registers = 0.
- All outputs are decoded from registered state and captured registers; no input-to-output combinational path except o_redirect_pc (from mtvec/mepc).
- Entry latency, with i_csr_ready tied high and exception seen at cycle N:
  - FLUSH at N+1;
  - WR_MEPC..WR_MSTATUS at N+2..N+5;
  - REDIRECT at N+6;
  - IDLE at N+7, when a new exception can be accepted.
- Return latency, MRET at N: FLUSH N+1, WR_MSTATUS N+2, REDIRECT N+3.
- Each cycle i_csr_ready is low adds one cycle to the current WR_* state.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs at reset values; no partial writes are re-issued.

## Configuration
- TRAP_SEQ_VECTORED_EN defined:
  - In entry REDIRECT, if i_mtvec[1:0]==2'b01 and captured cause[XLEN-1]==1, target = {mtvec[XLEN-1:2],2'b00} + (cause[XLEN-2:0] << 2), truncated to XLEN.
  - Otherwise the direct base is used.
- Undefined: mtvec[1:0] is ignored and the target is always the direct base.

## Test plan
- Exception cause=2, tval=0, pc=0x100, mtvec=0x200, mstatus=0x8, ready high:
  - flush at N+1;
  - writes (0x341,0x100), (0x342,2), (0x343,0), (0x300,0x1880);
  - redirect 0x200 at N+6.
- MRET with mstatus=0x1880, mepc=0x104:
  - single write (0x300,0x1888);
  - redirect 0x104 at N+3.
- i_csr_ready low for 3 cycles in WR_MCAUSE:
  - addr/data held stable;
  - redirect delayed to N+9;
  - no duplicate writes.
- Exception and MRET in the same cycle → entry sequence only. A second exception pulsed while busy → ignored; exactly 4 CSR writes.
- i_rst_n low during WR_MTVAL: all outputs 0 asynchronously; after release the block sits in IDLE with o_busy=0.
- With TRAP_SEQ_VECTORED_EN, mtvec=0x201, cause=0x80000007 → redirect 0x21C. Without the macro → redirect 0x200.
